// File: rtl/axil_regfile_slave_if.sv
// rtl/axil_regfile_slave_if.sv - AXI4-Lite bus bundle between the JTAG bridge master and the register file slave
interface axil_regfile_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_regfile_slave.sv
// rtl/axil_regfile_slave.sv - AXI4-Lite slave exposing NUM_REGS byte-writable registers at BASE_ADDR
// AW and W are held independently and committed together one edge after both are present.
module axil_regfile_slave #(
  parameter int                NUM_REGS  = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_areset,
  axil_regfile_slave_if.slave        s_axi,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        reg_wr_pulse
);

  localparam int                IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int                STRB_W      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] SPAN        = ADDR_W'(4 * NUM_REGS);
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;

  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              commit;
  logic              aw_held_n;
  logic              w_held_n;
  logic              bvalid_n;
  logic              rvalid_n;

  logic [ADDR_W:0]   aw_off;
  logic [ADDR_W:0]   ar_off;
  logic              aw_hit;
  logic              ar_hit;
  logic [IDX_W-1:0]  aw_idx;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] rd_sel;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    assign reg_out[gi*DATA_W +: DATA_W] = regs[gi];
  end

  // Borrow bit of the widened subtraction flags addresses below BASE_ADDR.
  always_comb begin
    aw_off = {1'b0, aw_addr} - {1'b0, BASE_ADDR};
    ar_off = {1'b0, s_axi.araddr} - {1'b0, BASE_ADDR};
    aw_hit = ~aw_off[ADDR_W] && (aw_off[ADDR_W-1:0] < SPAN);
    ar_hit = ~ar_off[ADDR_W] && (ar_off[ADDR_W-1:0] < SPAN);
    aw_idx = aw_off[IDX_W+1:2];
    ar_idx = ar_off[IDX_W+1:2];
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_sel = regs[i];
    end
  end

  always_comb begin
    aw_hs     = s_axi.awvalid & awready_q;
    w_hs      = s_axi.wvalid & wready_q;
    b_hs      = bvalid_q & s_axi.bready;
    ar_hs     = s_axi.arvalid & arready_q;
    r_hs      = rvalid_q & s_axi.rready;
    commit    = aw_held & w_held;
    aw_held_n = commit ? 1'b0 : (aw_held | aw_hs);
    w_held_n  = commit ? 1'b0 : (w_held | w_hs);
    bvalid_n  = commit | (bvalid_q & ~b_hs);
    rvalid_n  = ar_hs | (rvalid_q & ~r_hs);
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_addr      <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= RESP_OKAY;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rresp_q      <= RESP_OKAY;
      rdata_q      <= '0;
      reg_wr_pulse <= '0;
    end else begin
      aw_held      <= aw_held_n;
      w_held       <= w_held_n;
      bvalid_q     <= bvalid_n;
      rvalid_q     <= rvalid_n;
      // Readies track next-cycle state so they first rise one edge after reset release.
      awready_q    <= ~aw_held_n & ~bvalid_n;
      wready_q     <= ~w_held_n & ~bvalid_n;
      arready_q    <= ~rvalid_n;
      reg_wr_pulse <= '0;

      if (aw_hs) aw_addr <= s_axi.awaddr;
      if (w_hs) begin
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end

      if (commit) begin
        bresp_q <= aw_hit ? RESP_OKAY : RESP_SLVERR;
        if (aw_hit) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == IDX_W'(i)) begin
              reg_wr_pulse[i] <= 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
          end
        end
      end

      // Sampling regs at the same edge as a commit returns the pre-write value.
      if (ar_hs) begin
        rresp_q <= ar_hit ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= ar_hit ? rd_sel : '0;
      end
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb/tb_axil_regfile_slave.sv - scoreboard bench for the AXI4-Lite register file slave
module tb_axil_regfile_slave;

  localparam int          NUM_REGS = 4;
  localparam logic [31:0] BASE     = 32'h4000_0100;
  localparam logic [31:0] RST_VAL  = 32'hA5A5_0F0F;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REGS*32-1:0]   reg_out;
  logic [NUM_REGS-1:0]      reg_wr_pulse;

  axil_regfile_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_regfile_slave #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (32),
    .ADDR_W   (32),
    .BASE_ADDR(BASE),
    .RESET_VAL(RST_VAL)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .s_axi       (bus),
    .reg_out     (reg_out),
    .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  logic [31:0] mdl[NUM_REGS];
  int          pulse_cnt = 0;
  logic [3:0]  pulse_or  = '0;
  int          lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.bvalid && bus.bready) begin
        if (b_q.size() == 0) check("b_stray", bus.bvalid, 1'b0);
        else check("bresp", bus.bresp, b_q.pop_front());
      end
      if (bus.rvalid && bus.rready) begin
        if (r_q.size() == 0) check("r_stray", bus.rvalid, 1'b0);
        else check("rresp_rdata", {bus.rresp, bus.rdata}, r_q.pop_front());
      end
      if (|reg_wr_pulse) begin
        pulse_cnt++;
        pulse_or |= reg_wr_pulse;
      end
    end
  end

  function automatic logic hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * NUM_REGS));
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic send_aw(input logic [31:0] a);
    bit hs = 0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = bus.awready;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    check("aw_accept", hs, 1'b1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit hs = 0;
    bus.wdata  = d;
    bus.wstrb  = s;
    bus.wvalid = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = bus.wready;
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    check("w_accept", hs, 1'b1);
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit hs = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    for (int c = 0; c < 20 && !hs; c++) begin
      @(negedge clk); hs = bus.arready;
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    check("ar_accept", hs, 1'b1);
  endtask

  // w_lead > 0: W leads AW by that many cycles; w_lead < 0: AW leads W.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, output int latency);
    if (hit(a)) begin
      b_q.push_back(2'b00);
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx(a)][8*b +: 8] = d[8*b +: 8];
    end else begin
      b_q.push_back(2'b10);
    end
    @(posedge clk); #1;
    fork
      begin
        repeat (w_lead < 0 ? -w_lead : 0) begin @(posedge clk); #1; end
        send_w(d, s);
      end
      begin
        repeat (w_lead > 0 ? w_lead : 0) begin @(posedge clk); #1; end
        send_aw(a);
      end
    join
    latency = 0;
    while (!bus.bvalid && latency < 20) begin
      @(posedge clk); #1;
      latency++;
    end
    check("bvalid_seen", bus.bvalid, 1'b1);
  endtask

  task automatic axi_read(input logic [31:0] a);
    if (hit(a)) r_q.push_back({2'b00, mdl[idx(a)]});
    else r_q.push_back({2'b10, 32'h0});
    @(posedge clk); #1;
    send_ar(a);
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && (b_q.size() != 0 || r_q.size() != 0); c++) @(negedge clk);
    @(posedge clk); #1;
    check("b_drain", b_q.size(), 0);
    check("r_drain", r_q.size(), 0);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) check(tag, reg_out[i*32 +: 32], mdl[i]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = RST_VAL;
    b_q.delete();
    r_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    reset_model();

    // Reset release
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("bvalid_in_reset", bus.bvalid, 1'b0);
    rst = 1'b0;
    check_regs("reset_val");
    @(posedge clk); #1;
    check("ready_after_release", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // 1: same-cycle AW/W
    pulse_cnt = 0; pulse_or = '0;
    axi_write(BASE + 32'd4, 32'hDEAD_BEEF, 4'hF, 0, lat);
    check("t1_latency", lat, 1);
    drain();
    check("t1_reg1", reg_out[63:32], 32'hDEAD_BEEF);
    check("t1_pulse_mask", pulse_or, 4'b0010);
    check("t1_pulse_cycles", pulse_cnt, 1);
    check_regs("t1_regs");

    // 2: W three cycles ahead of AW, partial strobe
    axi_write(BASE, 32'hAAAA_AAAA, 4'hF, 0, lat);
    axi_write(BASE, 32'h1234_5678, 4'b0011, 3, lat);
    drain();
    check("t2_reg0", reg_out[31:0], 32'hAAAA_5678);
    check_regs("t2_regs");

    // 3: out-of-range accesses on both sides of the window
    pulse_cnt = 0;
    axi_write(BASE + 32'd16, 32'hFFFF_FFFF, 4'hF, 0, lat);
    axi_read(BASE + 32'd16);
    axi_write(BASE - 32'd4, 32'h5555_5555, 4'hF, -2, lat);
    axi_read(BASE - 32'd4);
    axi_read(BASE + 32'd12);
    drain();
    check("t3_no_pulse", pulse_cnt, 0);
    check_regs("t3_regs");

    // 4: read with rready held low
    axi_write(BASE + 32'd8, 32'h0BAD_F00D, 4'hF, 0, lat);
    drain();
    bus.rready = 1'b0;
    axi_read(BASE + 32'd8);
    for (int c = 0; c < 5; c++) begin
      check("t4_rvalid_hold", bus.rvalid, 1'b1);
      check("t4_rdata_hold", bus.rdata, 32'h0BAD_F00D);
      check("t4_arready_low", bus.arready, 1'b0);
      @(posedge clk); #1;
    end
    bus.rready = 1'b1;
    drain();

    // 5: AR lands on the same edge as a write commit to reg3
    axi_write(BASE + 32'd12, 32'h0000_0077, 4'hF, 0, lat);
    drain();
    @(posedge clk); #1;
    b_q.push_back(2'b00);
    bus.awaddr = BASE + 32'd12; bus.awvalid = 1'b1;
    bus.wdata = 32'h5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    r_q.push_back({2'b00, 32'h0000_0077});
    mdl[3] = 32'h5;
    bus.araddr = BASE + 32'd12; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    drain();
    axi_read(BASE + 32'd12);
    drain();
    check_regs("t5_regs");

    // Random mix including misses and unaligned low bits
    for (int n = 0; n < 12; n++) begin
      a = BASE - 32'd8 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2, lat);
      else
        axi_read(a);
      drain();
    end
    check_regs("rand_regs");

    // 6a: reset while AW is held
    @(posedge clk); #1;
    send_aw(BASE);
    #2 rst = 1'b1;
    #1;
    reset_model();
    check("t6a_ready_zero", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check_regs("t6a_regs_async");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_w(32'h1111_1111, 4'hF);
    for (int c = 0; c < 3; c++) begin
      check("t6a_no_commit", bus.bvalid, 1'b0);
      @(posedge clk); #1;
    end
    b_q.push_back(2'b00);
    mdl[0] = 32'h1111_1111;
    send_aw(BASE);
    drain();
    check_regs("t6a_regs");

    // 6b: reset while bvalid is pending
    bus.bready = 1'b0;
    axi_write(BASE + 32'd4, 32'h2222_2222, 4'hF, 0, lat);
    @(posedge clk); #1;
    check("t6b_bvalid_pending", bus.bvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    reset_model();
    check("t6b_bvalid_async", bus.bvalid, 1'b0);
    check("t6b_ready_zero", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check_regs("t6b_regs_async");
    bus.bready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t6b_no_stray_b", bus.bvalid, 1'b0);
      @(posedge clk); #1;
    end
    check_regs("t6b_regs");
    check("t6b_ready_back", {bus.awready, bus.wready, bus.arready}, 3'b111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
